// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_arb_pkg                                                     |
// | Purpose  : Shared types and constants for the IF/MEM memory-port arbiter:  |
// |            FSM state encoding, timeout fill word and width defaults.       |
// | Contents : arb_state_e, C_MEM_FILL, C_FAIR_W, C_*_DEF defaults             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

  localparam int unsigned C_ADDR_W_DEF      = 32;
  localparam int unsigned C_DATA_W_DEF      = 32;
  localparam int unsigned C_FAIR_MAX_DEF    = 4;
  localparam int unsigned C_TIMEOUT_CYC_DEF = 16;

  // Fairness counter width; FAIR_MAX is bounded to 1..15.
  localparam int unsigned C_FAIR_W = 4;

  // Word returned to the requester when an access is abandoned by the watchdog.
  localparam logic [31:0] C_MEM_FILL = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_I = 3'd1,
    ST_BUSY_D = 3'd2,
    ST_RESP_I = 3'd3,
    ST_RESP_D = 3'd4
  } arb_state_e;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_arb_timer                                                   |
// | Purpose  : Clear/increment watchdog counter with terminal-count compare.   |
// |            tc_o is high while the count sits at LIMIT-1, so a caller that  |
// |            qualifies it with inc_i sees the limit reached on that cycle.   |
// | Ports    : clk_i, rst_ni   clock / async active-low reset                  |
// |            clr_i           load count with 0 (wins over inc_i)             |
// |            inc_i           advance count by one (saturating)               |
// |            tc_o            count == LIMIT-1                                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mem_arb_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int unsigned C_CNT_W = $clog2(LIMIT + 1);
  localparam logic [C_CNT_W-1:0] C_TC = C_CNT_W'(LIMIT - 1);

  logic [C_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != C_TC)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == C_TC);

endmodule : mem_arb_timer
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                                |
// | Purpose  : Shares the single-ported unified memory between instruction     |
// |            fetch (IF) and load/store (MEM), drives the memory handshake,   |
// |            registers read data and generates pipeline stall enables.       |
// | Ports    : clk_i, rst_ni            clock / async active-low reset         |
// |            if_*                     fetch request/response                 |
// |            d_*                      data request/response                  |
// |            mem_*                    memory request/acknowledge             |
// |            pc_write_o, ifid_write_o, exmem_hold_o   stall controls         |
// |            mem_err_o                sticky watchdog timeout flag           |
// | Options  : MEM_TIMEOUT_EN - enables the BUSY watchdog (mem_arb_timer);     |
// |            without it mem_err_o is 0 and BUSY waits for mem_ack forever.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = C_ADDR_W_DEF,
  parameter int unsigned DATA_W      = C_DATA_W_DEF,
  parameter int unsigned FAIR_MAX    = C_FAIR_MAX_DEF,
  parameter int unsigned TIMEOUT_CYC = C_TIMEOUT_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // fetch port
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  // data port
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ready_o,
  // memory port
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  // pipeline control
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              exmem_hold_o,
  output logic              mem_err_o
);

  localparam logic [C_FAIR_W-1:0] C_FAIR_LIM = C_FAIR_W'(FAIR_MAX);
  localparam logic [DATA_W-1:0]   C_FILL     = DATA_W'(C_MEM_FILL);

  // Elaboration-time parameter sanity check.
  if ((FAIR_MAX < 1) || (FAIR_MAX > 15) || (TIMEOUT_CYC < 1)) begin : g_bad_param
    $error("mem_port_arbiter: FAIR_MAX must be 1..15 and TIMEOUT_CYC >= 1");
  end

  arb_state_e          state_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                if_ready_q;
  logic                d_ready_q;
  logic [C_FAIR_W-1:0] fair_cnt_q;
  logic [C_FAIR_W-1:0] fair_cnt_d;

  logic                w_grant_d;
  logic                w_timeout;

  // Data (older instruction) wins unless fetch has been starved FAIR_MAX times.
  assign w_grant_d = d_req_i && ((fair_cnt_q < C_FAIR_LIM) || !if_req_i);

  // Count only consecutive data grants that overtook a waiting fetch.
  always_comb begin
    fair_cnt_d = '0;
    if (if_req_i) begin
      fair_cnt_d = (fair_cnt_q == C_FAIR_LIM) ? C_FAIR_LIM : fair_cnt_q + 1'b1;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic w_busy;
  logic w_start;
  logic w_tc;
  logic mem_err_q;

  assign w_busy    = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
  assign w_start   = (state_q == ST_IDLE) && (d_req_i || if_req_i);
  // An ack on the limit cycle completes normally and does not flag an error.
  assign w_timeout = w_busy && !mem_ack_i && w_tc;

  mem_arb_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (w_start),
    .inc_i  (w_busy && !mem_ack_i),
    .tc_o   (w_tc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_err_q <= 1'b0;
    end else if (w_timeout) begin
      mem_err_q <= 1'b1;
    end
  end

  assign mem_err_o = mem_err_q;
`else
  assign w_timeout = 1'b0;
  assign mem_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      fair_cnt_q  <= '0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_grant_d) begin
            state_q     <= ST_BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we_i;
            mem_addr_q  <= d_addr_i;
            mem_wdata_q <= d_wdata_i;
            fair_cnt_q  <= fair_cnt_d;
          end else if (if_req_i) begin
            state_q    <= ST_BUSY_I;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= if_addr_i;
            fair_cnt_q <= '0;
          end
        end

        ST_BUSY_I: begin
          if (mem_ack_i || w_timeout) begin
            state_q    <= ST_RESP_I;
            mem_req_q  <= 1'b0;
            if_ready_q <= 1'b1;
            if_rdata_q <= mem_ack_i ? mem_rdata_i : C_FILL;
          end
        end

        ST_BUSY_D: begin
          if (mem_ack_i || w_timeout) begin
            state_q   <= ST_RESP_D;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            d_ready_q <= 1'b1;
            // Stores leave the load-data register untouched.
            if (!mem_we_q) begin
              d_rdata_q <= mem_ack_i ? mem_rdata_i : C_FILL;
            end
          end
        end

        // One-cycle response; no regrant so the requester can drop req.
        ST_RESP_I,
        ST_RESP_D: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic w_stall_i;
  logic w_stall_d;

  assign w_stall_i = if_req_i & ~if_ready_q;
  assign w_stall_d = d_req_i & ~d_ready_q;

  assign pc_write_o   = ~(w_stall_i | w_stall_d);
  assign ifid_write_o = ~(w_stall_i | w_stall_d);
  assign exmem_hold_o = w_stall_d;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_ready_o  = if_ready_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_ready_o   = d_ready_q;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_port_arbiter                                             |
// | Purpose  : Scoreboard bench for mem_port_arbiter. Directed stimulus pushes |
// |            expected memory transactions and read data into queues; a       |
// |            negedge monitor pops and compares on mem_ack / ready pulses.    |
// | Options  : MEM_TIMEOUT_EN - adds the watchdog scenario.                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } mem_exp_t;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        pc_write;
  logic        ifid_write;
  logic        exmem_hold;
  logic        mem_err;

  int          n_vec;
  int          n_err;
  int          busy_cycles;
  int          mem_wait;
  logic        mem_ack_en;
  int          wcnt;

  mem_exp_t    q_mem[$];
  logic [31:0] q_i[$];
  logic [31:0] q_d[$];

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .FAIR_MAX    (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .if_req_i     (if_req),
    .if_addr_i    (if_addr),
    .if_rdata_o   (if_rdata),
    .if_ready_o   (if_ready),
    .d_req_i      (d_req),
    .d_we_i       (d_we),
    .d_addr_i     (d_addr),
    .d_wdata_i    (d_wdata),
    .d_rdata_o    (d_rdata),
    .d_ready_o    (d_ready),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_ack_i    (mem_ack),
    .pc_write_o   (pc_write),
    .ifid_write_o (ifid_write),
    .exmem_hold_o (exmem_hold),
    .mem_err_o    (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a few fixed words, otherwise addr ^ 0x5A5A0000.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0040: mem_word = 32'h8C01_0004;
      32'h0000_0044: mem_word = 32'h0022_1820;
      32'h0000_0100: mem_word = 32'hCAFE_0100;
      default:       mem_word = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Memory model: acks after mem_wait wait cycles (0 = same cycle as mem_req).
  always @(posedge clk) begin
    if (!mem_req || mem_ack) wcnt <= 0;
    else                     wcnt <= wcnt + 1;
  end
  assign mem_ack   = mem_ack_en && mem_req && (wcnt == mem_wait);
  assign mem_rdata = mem_word(mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) begin
        busy_cycles++;
        if (q_mem.size() == 0) begin
          check("mem_req_unexpected", {31'd0, mem_req}, 32'd0);
        end else begin
          check("mem_addr", mem_addr, q_mem[0].addr);
          check("mem_we", {31'd0, mem_we}, {31'd0, q_mem[0].we});
          if (q_mem[0].we) check("mem_wdata", mem_wdata, q_mem[0].wdata);
          if (mem_ack) void'(q_mem.pop_front());
        end
      end
      if (if_ready) begin
        if (q_i.size() == 0) check("if_ready_unexpected", {31'd0, if_ready}, 32'd0);
        else                 check("if_rdata", if_rdata, q_i.pop_front());
      end
      if (d_ready) begin
        if (q_d.size() == 0) check("d_ready_unexpected", {31'd0, d_ready}, 32'd0);
        else                 check("d_rdata", d_rdata, q_d.pop_front());
      end
    end
  end

  // Fetch requester: n consecutive fetches, req held high between them.
  task automatic fetch_seq(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      int c;
      if_addr = base + 32'(4 * k);
      if_req  = 1'b1;
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!if_ready && c < 200);
      check("if_handshake", {31'd0, if_ready}, 32'd1);
      @(posedge clk);
      #1;
    end
    if_req = 1'b0;
  endtask

  // Data requester: n consecutive accesses; exmem_hold must track the stall.
  task automatic data_seq(input int n, input logic we, input logic [31:0] base,
                          input logic [31:0] wd);
    for (int k = 0; k < n; k++) begin
      int c;
      d_addr  = base + 32'(4 * k);
      d_we    = we;
      d_wdata = wd;
      d_req   = 1'b1;
      c = 0;
      do begin
        @(negedge clk);
        c++;
        check("exmem_hold", {31'd0, exmem_hold}, {31'd0, ~d_ready});
      end while (!d_ready && c < 200);
      check("d_handshake", {31'd0, d_ready}, 32'd1);
      @(posedge clk);
      #1;
    end
    d_req = 1'b0;
    d_we  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    n_vec = 0; n_err = 0; busy_cycles = 0;
    mem_wait = 0; mem_ack_en = 1'b1;
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_if_ready", {31'd0, if_ready}, 32'd0);
    check("rst_d_ready", {31'd0, d_ready}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_mem_err", {31'd0, mem_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_pc_write", {31'd0, pc_write}, 32'd1);
    check("idle_exmem_hold", {31'd0, exmem_hold}, 32'd0);
    @(posedge clk); #1;

    // 1: fetch only, zero-wait memory, cycle-exact latency and stall.
    q_mem.push_back('{addr: 32'h40, we: 1'b0, wdata: 32'h0});
    q_i.push_back(32'h8C01_0004);
    if_addr = 32'h40; if_req = 1'b1;
    @(negedge clk);                                    // cycle 0
    check("c0_mem_req", {31'd0, mem_req}, 32'd0);
    check("c0_pc_write", {31'd0, pc_write}, 32'd0);
    check("c0_ifid_write", {31'd0, ifid_write}, 32'd0);
    @(negedge clk);                                    // cycle 1
    check("c1_mem_req", {31'd0, mem_req}, 32'd1);
    check("c1_pc_write", {31'd0, pc_write}, 32'd0);
    @(negedge clk);                                    // cycle 2
    check("c2_if_ready", {31'd0, if_ready}, 32'd1);
    check("c2_if_rdata", if_rdata, 32'h8C01_0004);
    check("c2_pc_write", {31'd0, pc_write}, 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    check("c3_if_ready", {31'd0, if_ready}, 32'd0);
    @(posedge clk); #1;

    // 2: simultaneous requests; the load goes first.
    q_mem.push_back('{addr: 32'h100, we: 1'b0, wdata: 32'h0});
    q_mem.push_back('{addr: 32'h44,  we: 1'b0, wdata: 32'h0});
    q_d.push_back(32'hCAFE_0100);
    q_i.push_back(32'h0022_1820);
    fork
      fetch_seq(1, 32'h44);
      data_seq(1, 1'b0, 32'h100, 32'h0);
    join
    @(posedge clk); #1;

    // 3: fairness -- 4 data grants, fetch, 4 data, fetch, remaining data.
    for (int k = 0; k < 4; k++) q_mem.push_back('{addr: 32'h200 + 32'(4*k), we: 1'b0, wdata: 32'h0});
    q_mem.push_back('{addr: 32'h80, we: 1'b0, wdata: 32'h0});
    for (int k = 4; k < 8; k++) q_mem.push_back('{addr: 32'h200 + 32'(4*k), we: 1'b0, wdata: 32'h0});
    q_mem.push_back('{addr: 32'h84, we: 1'b0, wdata: 32'h0});
    for (int k = 8; k < 10; k++) q_mem.push_back('{addr: 32'h200 + 32'(4*k), we: 1'b0, wdata: 32'h0});
    for (int k = 0; k < 10; k++) q_d.push_back(32'h5A5A_0200 + 32'(4*k));
    q_i.push_back(32'h5A5A_0080);
    q_i.push_back(32'h5A5A_0084);
    fork
      fetch_seq(2, 32'h80);
      data_seq(10, 1'b0, 32'h200, 32'h0);
    join
    @(posedge clk); #1;

    // 4: store with 3 wait states; d_rdata keeps the last load value.
    mem_wait = 3;
    busy_cycles = 0;
    q_mem.push_back('{addr: 32'h300, we: 1'b1, wdata: 32'h1234});
    q_d.push_back(32'h5A5A_0224);
    data_seq(1, 1'b1, 32'h300, 32'h1234);
    check("store_busy_cycles", 32'(busy_cycles), 32'd4);
    mem_wait = 0;
    @(posedge clk); #1;

    // 5: reset asserted mid BUSY_D, then a normal fetch.
    mem_wait = 50;
    q_mem.push_back('{addr: 32'h400, we: 1'b0, wdata: 32'h0});
    d_addr = 32'h400; d_we = 1'b0; d_req = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!mem_req && c < 20);
    check("rstbusy_mem_req_up", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstbusy_mem_req_drop", {31'd0, mem_req}, 32'd0);
    check("rstbusy_d_rdata", d_rdata, 32'd0);
    check("rstbusy_if_rdata", if_rdata, 32'd0);
    d_req = 1'b0;
    q_mem.delete();
    mem_wait = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    q_mem.push_back('{addr: 32'h44, we: 1'b0, wdata: 32'h0});
    q_i.push_back(32'h0022_1820);
    fetch_seq(1, 32'h44);
    @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
    // 6: no ack -> watchdog forces completion after 16 BUSY cycles.
    mem_ack_en = 1'b0;
    busy_cycles = 0;
    q_mem.push_back('{addr: 32'h48, we: 1'b0, wdata: 32'h0});
    q_i.push_back(32'hDEAD_BEEF);
    fetch_seq(1, 32'h48);
    check("tmo_busy_cycles", 32'(busy_cycles), 32'd16);
    check("tmo_mem_err", {31'd0, mem_err}, 32'd1);
    void'(q_mem.pop_front());
    mem_ack_en = 1'b1;
    q_mem.push_back('{addr: 32'h40, we: 1'b0, wdata: 32'h0});
    q_i.push_back(32'h8C01_0004);
    fetch_seq(1, 32'h40);
    check("tmo_mem_err_sticky", {31'd0, mem_err}, 32'd1);
`else
    check("no_tmo_mem_err", {31'd0, mem_err}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("q_mem_drained", 32'(q_mem.size()), 32'd0);
    check("q_i_drained", 32'(q_i.size()), 32'd0);
    check("q_d_drained", 32'(q_d.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
